// File: rtl/log2_32_iter.sv
// Iterative floor-log2 of a 32-bit operand: 5-step binary search, one step per clock.
// Ports: Clock, Reset (async, active-high), Start/Input request; Output, Zero, IsPow2, Busy, Done.
module log2_32_iter (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [31:0] Input,
    output logic [4:0]  Output,
    output logic        Zero,
    output logic        IsPow2,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t      state;
    logic [31:0] v;
    logic [31:0] opnd;
    logic [4:0]  r;
    logic [2:0]  k;

    logic [5:0]  sh;
    logic [31:0] v_sh;
    logic [31:0] v_next;
    logic [4:0]  r_next;
    logic        pow2;

    // One search step: probe the upper 2^k bits of what remains.
    always_comb begin
        sh     = 6'd1 << k;
        v_sh   = v >> sh;
        v_next = v;
        r_next = r;
        if (v_sh != 32'd0) begin
            v_next    = v_sh;
            r_next[k] = 1'b1;
        end
    end

    assign pow2 = (opnd != 32'd0) && ((opnd & (opnd - 32'd1)) == 32'd0);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            v      <= 32'd0;
            opnd   <= 32'd0;
            r      <= 5'd0;
            k      <= 3'd4;
            Output <= 5'd0;
            Zero   <= 1'b0;
            IsPow2 <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        v     <= Input;
                        opnd  <= Input;
                        r     <= 5'd0;
                        k     <= 3'd4;
                        Busy  <= 1'b1;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    v <= v_next;
                    r <= r_next;
                    if (k == 3'd0) begin
                        // Last step: publish results from the untouched operand copy.
                        Output <= r_next;
                        Zero   <= (opnd == 32'd0);
                        IsPow2 <= pow2;
                        Done   <= 1'b1;
                        Busy   <= 1'b0;
                        k      <= 3'd4;
                        state  <= IDLE;
                    end else begin
                        k <= k - 3'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log2_32_iter.sv
// Directed-vector bench for log2_32_iter.
// Expected values are hand-computed constants.
module tb_log2_32_iter;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] Input = 32'd0;
    logic [4:0]  Output;
    logic        Zero;
    logic        IsPow2;
    logic        Busy;
    logic        Done;

    int n_vec = 0;
    int n_err = 0;

    log2_32_iter dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (Start),
        .Input  (Input),
        .Output (Output),
        .Zero   (Zero),
        .IsPow2 (IsPow2),
        .Busy   (Busy),
        .Done   (Done)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for Done; returns edges after the accepting edge, -1 on timeout.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clock);
            #1;
            if (Done) begin
                edges = c;
                break;
            end
        end
    endtask

    // Apply one operand; checks result, flags and latency (6 edges incl. accept).
    task automatic run_op(input string tag, input logic [31:0] val,
                          input logic [4:0] e_out, input logic e_zero,
                          input logic e_pow2);
        int e;
        @(negedge Clock);
        Start = 1'b1;
        Input = val;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        Input = 32'hDEAD_BEEF;
        wait_done(e);
        check({tag, "_lat"}, e + 1, 6);
        check({tag, "_out"}, Output, e_out);
        check({tag, "_zero"}, Zero, e_zero);
        check({tag, "_pow2"}, IsPow2, e_pow2);
    endtask

    initial begin
        int e;
        int ndone;
        logic bad;

        Reset = 1'b1;
        #12;
        check("rst_out", Output, 0);
        check("rst_zero", Zero, 0);
        check("rst_pow2", IsPow2, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        @(negedge Clock);
        Reset = 1'b0;

        bad = 1'b0;
        repeat (20) begin
            @(posedge Clock);
            #1;
            if (Done || Busy) bad = 1'b1;
        end
        check("idle_quiet", bad, 0);

        for (int i = 0; i < 32; i++)
            run_op($sformatf("pow%0d", i), 32'd1 << i, 5'(i), 1'b0, 1'b1);

        run_op("all1", 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0);
        run_op("three", 32'h0000_0003, 5'd1, 1'b0, 1'b0);
        run_op("x12345", 32'h0001_2345, 5'd16, 1'b0, 1'b0);
        run_op("zero", 32'h0000_0000, 5'd0, 1'b1, 1'b0);
        run_op("x80000001", 32'h8000_0001, 5'd31, 1'b0, 1'b0);

        // Start held high: second operand taken in first Done cycle.
        @(negedge Clock);
        Start = 1'b1;
        Input = 32'h100;
        @(posedge Clock);
        #1;
        Input = 32'h10;
        wait_done(e);
        check("hold1_lat", e + 1, 6);
        check("hold1_out", Output, 8);
        @(posedge Clock);
        #1;
        Start = 1'b0;
        check("hold2_busy", Busy, 1);
        wait_done(e);
        check("hold2_gap", e + 1, 6);
        check("hold2_out", Output, 4);

        // Start pulses while busy are ignored.
        @(negedge Clock);
        Start = 1'b1;
        Input = 32'h400;
        @(negedge Clock);
        Start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 3; c++) begin
            Input = 32'h1;
            Start = (c != 1);
            @(posedge Clock);
            #1;
            if (Done) ndone++;
            @(negedge Clock);
        end
        Start = 1'b0;
        repeat (12) begin
            @(posedge Clock);
            #1;
            if (Done) ndone++;
        end
        check("busy_pulse_ndone", ndone, 1);
        check("busy_pulse_out", Output, 10);

        // Reset two cycles into a search.
        @(negedge Clock);
        Start = 1'b1;
        Input = 32'h8000_0000;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        check("midrst_out", Output, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        @(negedge Clock);
        Reset = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(posedge Clock);
            #1;
            if (Done) ndone++;
        end
        check("midrst_nodone", ndone, 0);
        run_op("after_rst", 32'h40, 5'd6, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
